// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap/return sequencer: CSR addresses, trap causes,
// FSM encoding and the trap-vector target calculation.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL    = 32'd11;
  localparam logic [31:0] CAUSE_EX_IRQ   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_SOFT_IRQ = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TCMP_IRQ = 32'h8000_0007;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MTVAL,
    S_W_MSTATUS,
    S_JUMP,
    S_R_MSTATUS,
    S_JUMP_RET
  } trap_state_e;

  // Vectored mode only applies to interrupts; the offset wraps mod 2^32.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic [31:0] cause,
                                              input logic        vec_en);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (vec_en && (mtvec[1:0] == 2'b01) && cause[31]) begin
      return base + {cause[29:0], 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// Priority encoder for trap events seen by the idex stage: exceptions first,
// then mret, then globally-enabled interrupts.
module trap_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic        inst_valid_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        illegal_i,
  input  logic        mret_i,
  input  logic        ex_trap_i,
  input  logic        tcmp_trap_i,
  input  logic        soft_trap_i,
  input  logic        mstatus_mie_i,
  output logic        ev_valid_o,
  output logic [31:0] ev_cause_o,
  output logic        ev_mret_o
);

  always_comb begin
    ev_valid_o = 1'b0;
    ev_cause_o = 32'h0;
    ev_mret_o  = 1'b0;
    if (inst_valid_i) begin
      if (illegal_i) begin
        ev_valid_o = 1'b1;
        ev_cause_o = CAUSE_ILLEGAL;
      end else if (ebreak_i) begin
        ev_valid_o = 1'b1;
        ev_cause_o = CAUSE_EBREAK;
      end else if (ecall_i) begin
        ev_valid_o = 1'b1;
        ev_cause_o = CAUSE_ECALL;
      end else if (mret_i) begin
        ev_valid_o = 1'b1;
        ev_mret_o  = 1'b1;
      end else if (mstatus_mie_i && ex_trap_i) begin
        ev_valid_o = 1'b1;
        ev_cause_o = CAUSE_EX_IRQ;
      end else if (mstatus_mie_i && soft_trap_i) begin
        ev_valid_o = 1'b1;
        ev_cause_o = CAUSE_SOFT_IRQ;
      end else if (mstatus_mie_i && tcmp_trap_i) begin
        ev_valid_o = 1'b1;
        ev_cause_o = CAUSE_TCMP_IRQ;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: saves trap state through the CSR trap channel one
// access per cycle, holds the pipeline, then redirects the PC once.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [31:0] RESET_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        illegal_i,
  input  logic        mret_i,
  input  logic        ex_trap_i,
  input  logic        tcmp_trap_i,
  input  logic        soft_trap_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] mepc_i,
  output logic        trap_csr_we_o,
  output logic [11:0] trap_csr_addr_o,
  output logic [31:0] trap_csr_wdata_o,
  input  logic [31:0] trap_csr_rdata_i,
  output logic        hold_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o
);

  trap_state_e state, state_n;
  logic [31:0] cause_q, pc_q, tval_q;
  logic        ev_valid, ev_mret;
  logic [31:0] ev_cause;

  // Reset vector is owned by the fetch unit; kept only for the parameter list.
  logic unused_reset_addr;
  assign unused_reset_addr = ^RESET_ADDR;

  trap_prio_enc u_prio (
    .inst_valid_i  (inst_valid_i),
    .ecall_i       (ecall_i),
    .ebreak_i      (ebreak_i),
    .illegal_i     (illegal_i),
    .mret_i        (mret_i),
    .ex_trap_i     (ex_trap_i),
    .tcmp_trap_i   (tcmp_trap_i),
    .soft_trap_i   (soft_trap_i),
    .mstatus_mie_i (mstatus_mie_i),
    .ev_valid_o    (ev_valid),
    .ev_cause_o    (ev_cause),
    .ev_mret_o     (ev_mret)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cause_q <= 32'h0;
      pc_q    <= 32'h0;
      tval_q  <= 32'h0;
    end else begin
      state <= state_n;
      // Latched once at detect so later input changes cannot disturb the sequence.
      if ((state == S_IDLE) && ev_valid && !ev_mret) begin
        cause_q <= ev_cause;
        pc_q    <= pc_i;
        tval_q  <= (ev_cause == CAUSE_ILLEGAL) ? inst_i : 32'h0;
      end
    end
  end

  always_comb begin
    state_n          = state;
    trap_csr_we_o    = 1'b0;
    trap_csr_addr_o  = 12'h0;
    trap_csr_wdata_o = 32'h0;
    hold_o           = 1'b0;
    jump_o           = 1'b0;
    jump_addr_o      = 32'h0;
    unique case (state)
      S_IDLE: begin
        if (ev_valid) begin
          hold_o  = 1'b1;
          state_n = ev_mret ? S_R_MSTATUS : S_W_MEPC;
        end
      end
      S_W_MEPC: begin
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MEPC;
        trap_csr_wdata_o = pc_q;
        state_n          = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MCAUSE;
        trap_csr_wdata_o = cause_q;
        state_n          = S_W_MTVAL;
      end
      S_W_MTVAL: begin
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MTVAL;
        trap_csr_wdata_o = tval_q;
        state_n          = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        // Read-modify-write in one cycle: MPIE <= MIE, MIE <= 0.
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MSTATUS;
        trap_csr_wdata_o = {24'h0, trap_csr_rdata_i[3], 3'h0, 1'b0, 3'h0};
        state_n          = S_JUMP;
      end
      S_JUMP: begin
        hold_o          = 1'b1;
        trap_csr_addr_o = CSR_MTVEC;
        jump_o          = 1'b1;
        jump_addr_o     = trap_target(trap_csr_rdata_i, cause_q, VECTORED_EN);
        state_n         = S_IDLE;
      end
      S_R_MSTATUS: begin
        // mret: MIE <= MPIE, MPIE <= 1.
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MSTATUS;
        trap_csr_wdata_o = {24'h0, 1'b1, 3'h0, trap_csr_rdata_i[7], 3'h0};
        state_n          = S_JUMP_RET;
      end
      S_JUMP_RET: begin
        hold_o      = 1'b1;
        jump_o      = 1'b1;
        jump_addr_o = mepc_i;
        state_n     = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap/return sequencer; the initiator on the CSR block's trap channel (trap_csr_we/addr/wdata out, trap_csr_rdata in).
- Sits beside the idex stage. Takes synchronous exceptions from idex, masked interrupt requests from the CSR block, and mret.
- Writes mepc/mcause/mtval/mstatus one access per cycle, reads mtvec/mstatus, stalls the pipeline, then redirects the PC.

Parameters:
- VECTORED_EN, 1, 1: honour mtvec[1:0]==2'b01 vectored interrupt mode; 0: always jump to base.
- RESET_ADDR, 32'h0, reserved; unused by the datapath, kept for the top-level parameter list.

Ports:
- clk  in  1  clock; rising-edge
- rst_n  in  1  async reset, active-low
- inst_valid_i  in  1  idex holds a valid instruction this cycle
- pc_i  in  32  PC of the idex instruction
- inst_i  in  32  raw instruction word (becomes mtval for illegal)
- ecall_i / ebreak_i / illegal_i  in  1 each  decoded exceptions
- mret_i  in  1  mret decoded
- ex_trap_i / tcmp_trap_i / soft_trap_i  in  1 each  masked interrupt requests
- mstatus_mie_i  in  1  global interrupt enable
- mepc_i  in  32  current mepc
- trap_csr_we_o  out  1  trap-channel write enable
- trap_csr_addr_o  out  12  trap-channel CSR address
- trap_csr_wdata_o  out  32  trap-channel write data
- trap_csr_rdata_i  in  32  trap-channel read data; combinational response to addr
- hold_o  out  1  stall fetch/idex and suppress idex CSR writes
- jump_o  out  1  one-cycle PC redirect
- jump_addr_o  out  32  redirect target

Behaviour:
- Reset: state=IDLE; all outputs 0; latched cause, pc and tval cleared.
- Event priority in IDLE, sampled only when inst_valid_i=1:
  - 1. illegal_i, cause 2
  - 2. ebreak_i, cause 3
  - 3. ecall_i, cause 11
  - 4. mret_i
  - 5. interrupts, only when mstatus_mie_i=1: ex, cause 0x8000_000B; then soft, cause 0x8000_0003; then tcmp, cause 0x8000_0007
- Latching on detect:
  - Exception: mepc value = pc_i (faulting instruction); instruction is killed.
  - Interrupt: mepc value = pc_i (instruction not executed); instruction is killed.
  - tval = inst_i for illegal; 0 otherwise.
- hold_o:
  - Asserted combinationally in the detect cycle.
  - Stays high through the final JUMP state inclusive.
  - The CSR block gives idex writes priority, so hold_o guarantees no idex CSR write collides with the sequence.
- Trap FSM, one state per cycle:
  - W_MEPC: we=1, addr=MEPC, wdata=latched pc.
  - W_MCAUSE: we=1, addr=MCAUSE, wdata=cause.
  - W_MTVAL: we=1, addr=MTVAL, wdata=tval.
  - W_MSTATUS: addr=MSTATUS; read rdata same cycle; we=1, wdata={24'h0, MPIE=rdata[3], 3'h0, MIE=0, 3'h0}.
  - JUMP: we=0, addr=MTVEC; base={rdata[31:2], 2'b00}.
    - If VECTORED_EN, rdata[1:0]==01 and cause[31]: target = base + 4*cause[30:0]; else target = base.
    - jump_o=1 and jump_addr_o=target for exactly one cycle; then IDLE.
- Trap latency: detect cycle N → jump_o at cycle N+5.
- MRET FSM:
  - R_MSTATUS: addr=MSTATUS; we=1, wdata={24'h0, MPIE=1, 3'h0, MIE=rdata[7], 3'h0}.
  - JUMP_RET: jump_o=1, jump_addr_o=mepc_i.
  - Latency: detect N → jump_o at N+2.
- Outside the write states, trap_csr_we_o=0 and wdata=0.
- Events arriving while not IDLE are ignored; level interrupts are re-evaluated on return to IDLE.
- An interrupt deasserting mid-sequence does not alter latched state.
- rst_n low mid-sequence: immediate IDLE, outputs 0, no partial jump.
- Address arithmetic wraps mod 2^32.

Decomposition:
- Shared package / defines: CSR addresses (MSTATUS, MEPC, MCAUSE, MTVAL, MTVEC); cause constants; FSM state encoding.
- Optional sub-module trap_prio_enc: combinational priority encoder producing {valid, cause, is_mret}. Everything else stays in trap_ctrl.

Test Plan:
- mtvec=0x1000_0001, ecall_i at pc 0x80 → writes mepc=0x80, mcause=11, mtval=0, mstatus MIE=0/MPIE=old MIE; jump_addr=0x1000_0000 at detect+5; hold_o high 6 cycles.
- Same mtvec, tcmp_trap_i=1, mstatus_mie_i=1, pc 0x200 → mcause=0x8000_0007, mepc=0x200; jump to 0x1000_001C. With VECTORED_EN=0: jump to 0x1000_0000.
- illegal_i with inst_i=0xFFFF_FFFF and ex_trap_i together → exception wins: mcause=2, mtval=0xFFFF_FFFF; interrupt taken after return to IDLE.
- mret_i, mepc_i=0x344, mstatus MPIE=1 → mstatus write sets MIE=1, MPIE=1; jump_addr=0x344 at detect+2.
- mstatus_mie_i=0 with all interrupts high for 20 cycles → no hold_o, no jump_o, no writes.
- rst_n pulsed low during W_MCAUSE → all outputs 0 next cycle, no jump_o; a fresh ecall afterwards completes normally.
